// File: rtl/led_pkg.sv
// led_pkg: shared types and helpers for the LED pattern controller.
// Contents: mode enum (BLINK/RUN/BOUNCE/FILL), bounce direction type,
//           mode successor and per-mode entry-value functions.
package led_pkg;

   typedef enum logic [1:0] {
      BLINK  = 2'd0,
      RUN    = 2'd1,
      BOUNCE = 2'd2,
      FILL   = 2'd3
   } mode_t;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_t;

   // Width of the tick divider counter (covers TICK_DIV up to 255).
   localparam int DIV_W = 8;

   // Mode sequence on a mode_next request.
   function automatic mode_t mode_succ(input mode_t m);
      case (m)
         BLINK:   mode_succ = RUN;
         RUN:     mode_succ = BOUNCE;
         BOUNCE:  mode_succ = FILL;
         default: mode_succ = BLINK;
      endcase
   endfunction

   // Entry pattern of each mode. Every entry value is either 0 or 1, so
   // only the LSB is returned; callers zero-extend to the LED width.
   function automatic logic entry_value(input mode_t m);
      case (m)
         RUN, BOUNCE: entry_value = 1'b1;
         default:     entry_value = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/led_pwm_gate.sv
// led_pwm_gate: brightness gating of the LED pattern (used only with LED_PWM_EN).
// Ports: sys_clk/sys_rst_n clock and async active-low reset; pattern in;
//        led_duty on-time out of 256; led_out registered gated pattern.
module led_pwm_gate #(
   parameter int LED_W = 4
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic [LED_W-1:0] pattern,
   input  logic [7:0]       led_duty,
   output logic [LED_W-1:0] led_out
);

   logic [7:0] pwm_cnt;
   logic       pwm_on;

   // LEDs are on while the free-running counter is below the duty value:
   // duty 0 never lights, duty 255 lights for 255 of 256 cycles.
   assign pwm_on = (pwm_cnt < led_duty);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pwm_cnt <= '0;
         led_out <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 8'd1;
         led_out <= pattern & {LED_W{pwm_on}};
      end
   end

endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: turns timebase ticks into BLINK/RUN/BOUNCE/FILL LED patterns.
// Ports: sys_clk, sys_rst_n (async active-low); tick_in timebase pulse; mode_next
//        mode advance pulse; led_out LEDs; mode_o current mode; step_o update pulse.
// Optional: LED_PWM_EN adds led_duty[7:0] and a registered PWM gate on led_out.
module led_pattern_ctrl
   import led_pkg::*;
#(
   parameter int LED_W    = 4,
   parameter int TICK_DIV = 1
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             tick_in,
   input  logic             mode_next,
`ifdef LED_PWM_EN
   input  logic [7:0]       led_duty,
`endif
   output logic [LED_W-1:0] led_out,
   output logic [1:0]       mode_o,
   output logic             step_o
);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   mode_t            state, next_state;
   dir_t             dir, dir_step;
   logic [DIV_W-1:0] div_cnt;
   logic [LED_W-1:0] pattern, pattern_step, pattern_entry;
   logic             step;

   assign step = tick_in && (div_cnt == DIV_LAST);

   // ---------------- mode FSM: state register ----------------
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= BLINK;
      end else begin
         state <= next_state;
      end
   end

   // ---------------- mode FSM: next state ----------------
   always_comb begin
      next_state = state;
      if (mode_next) begin
         next_state = mode_succ(state);
      end
   end

   // ---------------- mode FSM: outputs ----------------
   always_comb begin
      mode_o = state;
   end

   // Entry pattern of the mode being entered on a mode change.
   assign pattern_entry = {{(LED_W-1){1'b0}}, entry_value(next_state)};

   // Next pattern and bounce direction for a step in the current mode.
   always_comb begin
      pattern_step = pattern;
      dir_step     = dir;
      case (state)
         BLINK: begin
            pattern_step = ~pattern;
         end
         RUN: begin
            pattern_step = {pattern[LED_W-2:0], pattern[LED_W-1]};
         end
         BOUNCE: begin
            // Direction flips in the same step that reaches an end LED, so
            // the end LED is shown exactly once per sweep.
            if (dir == UP) begin
               pattern_step = pattern << 1;
               dir_step     = pattern_step[LED_W-1] ? DOWN : UP;
            end else begin
               pattern_step = pattern >> 1;
               dir_step     = pattern_step[0] ? UP : DOWN;
            end
         end
         default: begin
            pattern_step = (&pattern) ? '0 : ((pattern << 1) | {{(LED_W-1){1'b0}}, 1'b1});
         end
      endcase
   end

   // Pattern datapath. A mode change takes priority over a coincident step:
   // the step is dropped and the new mode starts from its entry value.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         pattern <= '0;
         div_cnt <= '0;
         dir     <= UP;
         step_o  <= 1'b0;
      end else if (mode_next) begin
         pattern <= pattern_entry;
         div_cnt <= '0;
         dir     <= UP;
         step_o  <= 1'b0;
      end else begin
         step_o <= step;
         if (tick_in) begin
            div_cnt <= step ? '0 : div_cnt + 1'b1;
         end
         if (step) begin
            pattern <= pattern_step;
            dir     <= dir_step;
         end
      end
   end

`ifdef LED_PWM_EN
   led_pwm_gate #(
      .LED_W (LED_W)
   ) u_pwm_gate (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .pattern   (pattern),
      .led_duty  (led_duty),
      .led_out   (led_out)
   );
`else
   assign led_out = pattern;
`endif

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed bench for led_pattern_ctrl.
// Two instances: u_dut (TICK_DIV=1) for the pattern sequences and reset,
// u_dut3 (TICK_DIV=3) for tick division and mode/step collision.
module tb_led_pattern_ctrl;

   logic       sys_clk = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       tick_in = 1'b0;
   logic       mode_next = 1'b0;
   logic       tick3 = 1'b0;
   logic       mode_next3 = 1'b0;
   logic [3:0] led_out, led3;
   logic [1:0] mode_o, mode3;
   logic       step_o, step3;
`ifdef LED_PWM_EN
   logic [7:0] led_duty = 8'd0;
`endif

   int checks = 0;
   int errors = 0;

   always #5 sys_clk = ~sys_clk;

   led_pattern_ctrl #(.LED_W(4), .TICK_DIV(1)) u_dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .tick_in   (tick_in),
      .mode_next (mode_next),
`ifdef LED_PWM_EN
      .led_duty  (led_duty),
`endif
      .led_out   (led_out),
      .mode_o    (mode_o),
      .step_o    (step_o)
   );

   led_pattern_ctrl #(.LED_W(4), .TICK_DIV(3)) u_dut3 (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .tick_in   (tick3),
      .mode_next (mode_next3),
`ifdef LED_PWM_EN
      .led_duty  (led_duty),
`endif
      .led_out   (led3),
      .mode_o    (mode3),
      .step_o    (step3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Pattern check; with the PWM gate the output is duty-gated and delayed,
   // so only the ungated build compares the raw pattern sequence.
   task automatic chk_led(input string tag, input logic [3:0] obs, input logic [3:0] exp);
`ifndef LED_PWM_EN
      chk(tag, {28'd0, obs}, {28'd0, exp});
`endif
   endtask

   // One tick on u_dut; called and returns at a negedge.
   task automatic tick1();
      tick_in = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      tick_in = 1'b0;
   endtask

   // n ticks; expected led_out after tick i is nibble i of vals.
   task automatic run_seq(input string tag, input int n, input logic [31:0] vals);
      for (int i = 0; i < n; i++) begin
         tick1();
         chk_led($sformatf("%s_led%0d", tag, i), led_out, vals[4*i +: 4]);
         chk($sformatf("%s_step%0d", tag, i), {31'd0, step_o}, 32'd1);
      end
   endtask

   task automatic next_mode(input string tag, input logic [1:0] exp_mode, input logic [3:0] exp_led);
      mode_next = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      mode_next = 1'b0;
      chk({tag, "_mode"}, {30'd0, mode_o}, {30'd0, exp_mode});
      chk_led({tag, "_led"}, led_out, exp_led);
      chk({tag, "_step"}, {31'd0, step_o}, 32'd0);
   endtask

   initial begin
      // ---- reset state ----
      repeat (3) @(negedge sys_clk);
      chk("rst_led", {28'd0, led_out}, 32'd0);
      chk("rst_mode", {30'd0, mode_o}, 32'd0);
      chk("rst_step", {31'd0, step_o}, 32'd0);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      chk("idle_led", {28'd0, led_out}, 32'd0);

      // ---- 1: BLINK 0,F,0,F,0 ----
      run_seq("blink", 4, 32'h0000_0F0F);
      @(negedge sys_clk);
      chk("blink_step_low", {31'd0, step_o}, 32'd0);
      chk_led("blink_hold", led_out, 4'h0);

      // ---- 2: RUN 1,2,4,8,1,2 ----
      next_mode("to_run", 2'd1, 4'h1);
      run_seq("run", 5, 32'h0002_1842);

      // ---- 3: BOUNCE 1,2,4,8,4,2,1,2,4 ----
      next_mode("to_bounce", 2'd2, 4'h1);
      run_seq("bounce", 8, 32'h4212_4842);

      // ---- 4: FILL 0,1,3,7,F,0,1 ----
      next_mode("to_fill", 2'd3, 4'h0);
      run_seq("fill", 6, 32'h0010_F731);
      next_mode("wrap_blink", 2'd0, 4'h0);

      // ---- 5: TICK_DIV=3, consecutive ticks, RUN ----
      mode_next3 = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      mode_next3 = 1'b0;
      chk("d3_mode", {30'd0, mode3}, 32'd1);
      chk_led("d3_entry", led3, 4'h1);
      tick3 = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(posedge sys_clk);
         @(negedge sys_clk);
         if (k == 7) tick3 = 1'b0;
         chk_led($sformatf("d3_led%0d", k), led3, (k < 3) ? 4'h1 : ((k < 6) ? 4'h2 : 4'h4));
         chk($sformatf("d3_step%0d", k), {31'd0, step3}, (k == 3 || k == 6) ? 32'd1 : 32'd0);
      end
      // div count now 1; one more tick brings it to the last count
      tick3 = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      tick3 = 1'b0;
      chk_led("d3_pre", led3, 4'h4);
      chk("d3_pre_step", {31'd0, step3}, 32'd0);

      // ---- 6: mode_next and step in the same cycle ----
      tick3 = 1'b1;
      mode_next3 = 1'b1;
      @(posedge sys_clk);
      @(negedge sys_clk);
      tick3 = 1'b0;
      mode_next3 = 1'b0;
      chk("coll_mode", {30'd0, mode3}, 32'd2);
      chk_led("coll_led", led3, 4'h1);
      chk("coll_step", {31'd0, step3}, 32'd0);
      // divider restarted on entry: third tick steps
      for (int k = 1; k <= 3; k++) begin
         tick3 = 1'b1;
         @(posedge sys_clk);
         @(negedge sys_clk);
         tick3 = 1'b0;
         chk_led($sformatf("coll_after%0d", k), led3, (k == 3) ? 4'h2 : 4'h1);
         chk($sformatf("coll_step%0d", k), {31'd0, step3}, (k == 3) ? 32'd1 : 32'd0);
      end

      // ---- 7: async reset mid-pattern ----
      next_mode("to_run2", 2'd1, 4'h1);
      tick1();
      chk_led("pre_rst_led", led_out, 4'h2);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("arst_led", {28'd0, led_out}, 32'd0);
      chk("arst_mode", {30'd0, mode_o}, 32'd0);
      chk("arst_mode3", {30'd0, mode3}, 32'd0);
      chk("arst_led3", {28'd0, led3}, 32'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);

      // ---- mode_next held two cycles advances twice ----
      mode_next = 1'b1;
      @(posedge sys_clk);
      @(posedge sys_clk);
      @(negedge sys_clk);
      mode_next = 1'b0;
      chk("held_mode", {30'd0, mode_o}, 32'd2);
      chk_led("held_led", led_out, 4'h1);

`ifdef LED_PWM_EN
      // ---- 8: PWM duty 64 on BLINK at F ----
      begin
         int on_cnt[4];
         next_mode("pwm_fill", 2'd3, 4'h0);
         next_mode("pwm_blink", 2'd0, 4'h0);
         tick1();
         led_duty = 8'd64;
         repeat (3) @(negedge sys_clk);
         for (int b = 0; b < 4; b++) on_cnt[b] = 0;
         for (int c = 0; c < 256; c++) begin
            for (int b = 0; b < 4; b++) if (led_out[b] === 1'b1) on_cnt[b]++;
            @(negedge sys_clk);
         end
         for (int b = 0; b < 4; b++) chk($sformatf("pwm64_led%0d", b), on_cnt[b], 32'd64);
         led_duty = 8'd0;
         repeat (3) @(negedge sys_clk);
         on_cnt[0] = 0;
         for (int c = 0; c < 256; c++) begin
            if (led_out !== 4'h0) on_cnt[0]++;
            @(negedge sys_clk);
         end
         chk("pwm0_off", on_cnt[0], 32'd0);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
